// File: rtl/mul_ctrl_pkg.sv
// Shared types and helpers for the RV32M multiply sequencing controller.
package mul_ctrl_pkg;

    typedef enum logic [2:0] {
        OpMul    = 3'b000,
        OpMulh   = 3'b001,
        OpMulhsu = 3'b010,
        OpMulhu  = 3'b011
    } mul_op_t;

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StWait,
        StDrain,
        StResp
    } mul_ctrl_state_t;

    // Returns {signed_a, signed_b}; MUL uses u/u since the low half does not depend on it.
    function automatic logic [1:0] mul_op_signedness(mul_op_t op);
        logic [1:0] s;
        case (op)
            OpMulh:   s = 2'b11;
            OpMulhsu: s = 2'b10;
            default:  s = 2'b00;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] mul_select(mul_op_t op, logic [63:0] prod);
        return (op == OpMul) ? prod[31:0] : prod[63:32];
    endfunction

endpackage

// File: rtl/mul_ctrl_if.sv
// Execute-stage request/response and multiplier handshake bundle for mul_ctrl.
interface mul_ctrl_if;
    logic        req_valid;
    logic [2:0]  req_funct3;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic        flush;
    logic        busy;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        mul_en;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_signed_a;
    logic        mul_signed_b;
    logic        mul_ready;
    logic [63:0] mul_out;

    modport slave (
        input  req_valid, req_funct3, req_rs1, req_rs2, flush, mul_ready, mul_out,
        output busy, resp_valid, resp_data, mul_en, mul_a, mul_b, mul_signed_a, mul_signed_b
    );

    modport master (
        output req_valid, req_funct3, req_rs1, req_rs2, flush, mul_ready, mul_out,
        input  busy, resp_valid, resp_data, mul_en, mul_a, mul_b, mul_signed_a, mul_signed_b
    );
endinterface

// File: rtl/mul_result_cache.sv
// One-entry product cache: remembers the last full 64-bit product with its operands and
// signedness so a MUL/MULH* pair on the same operands needs only one multiplier launch.
module mul_result_cache
    import mul_ctrl_pkg::*;
#(
    parameter bit CACHE_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_wr_en,
    input  logic [31:0] i_wr_a,
    input  logic [31:0] i_wr_b,
    input  logic        i_wr_sa,
    input  logic        i_wr_sb,
    input  logic [63:0] i_wr_prod,
    input  logic [31:0] i_lk_a,
    input  logic [31:0] i_lk_b,
    input  logic        i_lk_sa,
    input  logic        i_lk_sb,
    input  logic        i_lk_is_mul,
    output logic        o_hit,
    output logic [63:0] o_prod
);

    logic        r_valid;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic        r_sa;
    logic        r_sb;
    logic [63:0] r_prod;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_prod  <= '0;
        end else if (i_wr_en) begin
            r_valid <= 1'b1;
            r_a     <= i_wr_a;
            r_b     <= i_wr_b;
            r_sa    <= i_wr_sa;
            r_sb    <= i_wr_sb;
            r_prod  <= i_wr_prod;
        end
    end

    // Low half is signedness-independent, so MUL matches regardless of cached signedness.
    assign o_hit = CACHE_EN && r_valid && (i_lk_a == r_a) && (i_lk_b == r_b) &&
                   (i_lk_is_mul || ({i_lk_sa, i_lk_sb} == {r_sa, r_sb}));
    assign o_prod = r_prod;

endmodule

// File: rtl/mul_ctrl.sv
// Sequencing controller between execute and the iterative 32x32 multiplier: decodes RV32M
// multiplies, launches the multiplier, stalls the pipeline and returns the selected half.
module mul_ctrl
    import mul_ctrl_pkg::*;
#(
    parameter bit CACHE_EN = 1'b1
) (
    input logic       clk,
    input logic       rst,
    mul_ctrl_if.slave bus
);

    mul_ctrl_state_t r_state;
    mul_ctrl_state_t w_state_nxt;
    mul_op_t         r_op;
    logic [31:0]     r_a;
    logic [31:0]     r_b;
    logic            r_sa;
    logic            r_sb;
    logic [31:0]     r_resp_data;

    mul_op_t         w_op;
    logic [1:0]      w_sign;
    logic            w_accept;
    logic            w_hit;
    logic [63:0]     w_cache_prod;
    logic            w_capture;
    logic            w_busy;
    logic            w_mul_en;
    logic            w_resp_valid;

    assign w_op      = mul_op_t'(bus.req_funct3);
    assign w_sign    = mul_op_signedness(w_op);
    assign w_accept  = (r_state == StIdle) && bus.req_valid && !bus.flush;
    assign w_capture = bus.mul_ready && ((r_state == StWait) || (r_state == StDrain));

    mul_result_cache #(
        .CACHE_EN (CACHE_EN)
    ) u_cache (
        .clk         (clk),
        .rst         (rst),
        .i_wr_en     (w_capture),
        .i_wr_a      (r_a),
        .i_wr_b      (r_b),
        .i_wr_sa     (r_sa),
        .i_wr_sb     (r_sb),
        .i_wr_prod   (bus.mul_out),
        .i_lk_a      (bus.req_rs1),
        .i_lk_b      (bus.req_rs2),
        .i_lk_sa     (w_sign[1]),
        .i_lk_sb     (w_sign[0]),
        .i_lk_is_mul (w_op == OpMul),
        .o_hit       (w_hit),
        .o_prod      (w_cache_prod)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_busy       = 1'b0;
        w_mul_en     = 1'b0;
        w_resp_valid = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_busy = w_accept;
                if (w_accept) begin
                    w_state_nxt = w_hit ? StResp : StLaunch;
                end
            end
            StLaunch: begin
                w_busy      = 1'b1;
                w_mul_en    = 1'b1;
                w_state_nxt = bus.flush ? StDrain : StWait;
            end
            StWait: begin
                w_busy = 1'b1;
                // A flush coinciding with the product needs no drain: it is already captured.
                if (bus.mul_ready) begin
                    w_state_nxt = bus.flush ? StIdle : StResp;
                end else if (bus.flush) begin
                    w_state_nxt = StDrain;
                end
            end
            StDrain: begin
                w_busy = 1'b1;
                if (bus.mul_ready) begin
                    w_state_nxt = StIdle;
                end
            end
            StResp: begin
                w_resp_valid = !bus.flush;
                w_state_nxt  = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_op        <= OpMul;
            r_a         <= '0;
            r_b         <= '0;
            r_sa        <= 1'b0;
            r_sb        <= 1'b0;
            r_resp_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_op <= w_op;
                r_a  <= bus.req_rs1;
                r_b  <= bus.req_rs2;
                r_sa <= w_sign[1];
                r_sb <= w_sign[0];
            end
            if (w_accept && w_hit) begin
                r_resp_data <= mul_select(w_op, w_cache_prod);
            end else if ((r_state == StWait) && bus.mul_ready && !bus.flush) begin
                r_resp_data <= mul_select(r_op, bus.mul_out);
            end
        end
    end

    assign bus.busy         = w_busy;
    assign bus.resp_valid   = w_resp_valid;
    assign bus.resp_data    = r_resp_data;
    assign bus.mul_en       = w_mul_en;
    assign bus.mul_a        = r_a;
    assign bus.mul_b        = r_b;
    assign bus.mul_signed_a = r_sa;
    assign bus.mul_signed_b = r_sb;

endmodule
